// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m: two-master round-robin arbiter sharing one slave bus, one owner per transaction.
// Optional stall timeout is compiled in when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter_2m #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic [1:0]            m0_response,
    output logic                  m0_waitrequest,

    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic [1:0]            m1_response,
    output logic                  m1_waitrequest,

    output logic [ADDR_W-1:0]     s_addr,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic [1:0]            s_response,
    input  logic                  s_waitrequest,

    output logic                  timeout_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                w_owner_nxt;
    logic                r_last;
    logic                w_last_nxt;

    logic                w_req0;
    logic                w_req1;
    logic [ADDR_W-1:0]   w_own_addr;
    logic                w_own_read;
    logic                w_own_write;
    logic [DATA_W-1:0]   w_own_wdata;
    logic [BE_W-1:0]     w_own_be;
    logic                w_own_req;
    logic                w_done;
    logic                w_tmo_hit;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // Request payload of the current owner; only meaningful while BUSY.
    always_comb begin
        w_own_addr  = m0_addr;
        w_own_read  = m0_read;
        w_own_write = m0_write;
        w_own_wdata = m0_writedata;
        w_own_be    = m0_byteenable;
        if (r_owner) begin
            w_own_addr  = m1_addr;
            w_own_read  = m1_read;
            w_own_write = m1_write;
            w_own_wdata = m1_writedata;
            w_own_be    = m1_byteenable;
        end
    end

    assign w_own_req = w_own_read | w_own_write;
    assign w_done    = w_own_req & ~s_waitrequest;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_tmo_cnt;

    // Stall counter: held at zero in IDLE so it starts clean on every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_tmo_cnt <= '0;
        end else if (s_waitrequest) begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end

    assign w_tmo_hit = (r_state == ST_BUSY) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [CNT_W-1:0] w_unused_tmo_cfg;

    assign w_unused_tmo_cfg = CNT_W'(TIMEOUT_CYCLES);
    assign w_tmo_hit        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state: arbitrate in IDLE, release on completion, protocol drop or timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_state_nxt = ST_BUSY;
                    w_owner_nxt = (w_req0 && w_req1) ? ~r_last : w_req1;
                end
            end
            ST_BUSY: begin
                if (w_tmo_hit || !w_own_req || w_done) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_owner;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs: slave sees the owner's request, owner sees the slave's reply.
    always_comb begin
        s_addr         = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_readdata    = '0;
        m0_response    = 2'b00;
        m0_waitrequest = 1'b1;
        m1_readdata    = '0;
        m1_response    = 2'b00;
        m1_waitrequest = 1'b1;
        timeout_o      = 1'b0;
        if (r_state == ST_BUSY) begin
            s_addr       = w_own_addr;
            s_writedata  = w_own_wdata;
            s_byteenable = w_own_be;
            if (w_tmo_hit) begin
                timeout_o = 1'b1;
                if (r_owner) begin
                    m1_waitrequest = 1'b0;
                    m1_response    = 2'b11;
                end else begin
                    m0_waitrequest = 1'b0;
                    m0_response    = 2'b11;
                end
            end else begin
                s_read  = w_own_read;
                s_write = w_own_write;
                if (r_owner) begin
                    m1_waitrequest = s_waitrequest;
                    m1_readdata    = s_readdata;
                    m1_response    = s_response;
                end else begin
                    m0_waitrequest = s_waitrequest;
                    m0_readdata    = s_readdata;
                    m0_response    = s_response;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed, table-driven bench for bus_arbiter_2m, plus hand sequences for reset and timeout.
// Define BUS_ARB_TIMEOUT_EN for both files to exercise the timeout path (TIMEOUT_CYCLES=16).
module tb_bus_arbiter_2m;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned TO = 16;

    localparam logic [31:0] M0_ADDR = 32'h0000_0040;
    localparam logic [31:0] M0_WD   = 32'hA5A5_0000;
    localparam logic [3:0]  M0_BE   = 4'b1111;
    localparam logic [31:0] M1_ADDR = 32'h1000_0004;
    localparam logic [31:0] M1_WD   = 32'h1234_5678;
    localparam logic [3:0]  M1_BE   = 4'b0011;

    logic          clk, rst_n;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic [1:0]    m0_response, m1_response, s_response;
    logic          m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic          timeout_o;

    int n_vec = 0;
    int n_bad = 0;

    bus_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_response(m0_response), .m0_waitrequest(m0_waitrequest),
        .m1_addr(m1_addr), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_response(m1_response), .m1_waitrequest(m1_waitrequest),
        .s_addr(s_addr), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_response(s_response), .s_waitrequest(s_waitrequest),
        .timeout_o(timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // in = {m0_read, m0_write, m1_read, m1_write}; own: 0 none, 1 m0, 2 m1 (selects forwarded addr/data/be)
    typedef struct {
        string       name;
        logic [3:0]  in;
        logic        sw;
        logic [31:0] srd;
        logic [1:0]  srsp;
        logic [1:0]  own;
        logic [1:0]  e_rw;
        logic [1:0]  e_wait;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rsp0;
        logic [1:0]  e_rsp1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [3:0] in, input logic sw,
                                input logic [31:0] srd, input logic [1:0] srsp, input logic [1:0] own,
                                input logic [1:0] e_rw, input logic [1:0] e_wait,
                                input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                                input logic [1:0] e_rsp0, input logic [1:0] e_rsp1);
        vec_t v;
        v.name = n; v.in = in; v.sw = sw; v.srd = srd; v.srsp = srsp; v.own = own;
        v.e_rw = e_rw; v.e_wait = e_wait; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        v.e_rsp0 = e_rsp0; v.e_rsp1 = e_rsp1;
        return v;
    endfunction

    function automatic logic [140:0] snap();
        return {timeout_o, s_read, s_write, s_addr, s_writedata, s_byteenable,
                m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata, m0_response, m1_response};
    endfunction

    function automatic logic [140:0] expv(input vec_t v);
        logic [31:0] a, wd;
        logic [3:0]  be;
        a = '0; wd = '0; be = '0;
        if (v.own == 2'd1) begin a = M0_ADDR; wd = M0_WD; be = M0_BE; end
        if (v.own == 2'd2) begin a = M1_ADDR; wd = M1_WD; be = M1_BE; end
        return {1'b0, v.e_rw, a, wd, be, v.e_wait, v.e_rd0, v.e_rd1, v.e_rsp0, v.e_rsp1};
    endfunction

    task automatic check(input string nm, input logic [140:0] act, input logic [140:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        {m0_read, m0_write, m1_read, m1_write} = v.in;
        s_waitrequest = v.sw;
        s_readdata    = v.srd;
        s_response    = v.srsp;
        #1;
        check(v.name, snap(), expv(v));
    endtask

    initial begin
        logic ok;
        rst_n = 1'b0;
        m0_addr = M0_ADDR; m0_writedata = M0_WD; m0_byteenable = M0_BE;
        m1_addr = M1_ADDR; m1_writedata = M1_WD; m1_byteenable = M1_BE;
        {m0_read, m0_write, m1_read, m1_write} = 4'b0000;
        s_waitrequest = 1'b0; s_readdata = '0; s_response = 2'b00;

        //         name         in      sw    srd           rsp    own   rw     wait   rd0           rd1           r0     r1
        vecs.push_back(mk("rst_idle",  4'b0000, 1'b0, 32'hCAFEF00D, 2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t1_arb",    4'b1000, 1'b1, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t1_stall1", 4'b1000, 1'b1, 32'h0,        2'b00, 2'd1, 2'b10, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t1_stall2", 4'b1000, 1'b1, 32'h0,        2'b00, 2'd1, 2'b10, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t1_done",   4'b1000, 1'b0, 32'hDEADBEEF, 2'b00, 2'd1, 2'b10, 2'b01, 32'hDEADBEEF, 32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t1_idle",   4'b0000, 1'b0, 32'hDEADBEEF, 2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t3_arb",    4'b0001, 1'b1, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t3_stall",  4'b0001, 1'b1, 32'h0,        2'b00, 2'd2, 2'b01, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t3_done",   4'b0001, 1'b0, 32'h0,        2'b00, 2'd2, 2'b01, 2'b10, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t2_arb0",   4'b1010, 1'b0, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t2_g0",     4'b1010, 1'b0, 32'h11111111, 2'b00, 2'd1, 2'b10, 2'b01, 32'h11111111, 32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t2_arb1",   4'b1010, 1'b0, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t2_g1",     4'b1010, 1'b0, 32'h22222222, 2'b00, 2'd2, 2'b10, 2'b10, 32'h0,        32'h22222222, 2'b00, 2'b00));
        vecs.push_back(mk("t2_arb2",   4'b1010, 1'b0, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t2_g2",     4'b1010, 1'b0, 32'h33333333, 2'b00, 2'd1, 2'b10, 2'b01, 32'h33333333, 32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t2_arb3",   4'b1010, 1'b0, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t2_g3",     4'b1010, 1'b0, 32'h44444444, 2'b00, 2'd2, 2'b10, 2'b10, 32'h0,        32'h44444444, 2'b00, 2'b00));
        vecs.push_back(mk("t2_idle",   4'b0000, 1'b0, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t6_arb",    4'b1010, 1'b1, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t6_stall",  4'b1010, 1'b1, 32'h0,        2'b00, 2'd1, 2'b10, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t6_drop",   4'b0010, 1'b1, 32'h0,        2'b00, 2'd1, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t6_arb1",   4'b0010, 1'b1, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("t6_g1",     4'b0010, 1'b0, 32'h55AA55AA, 2'b00, 2'd2, 2'b10, 2'b10, 32'h0,        32'h55AA55AA, 2'b00, 2'b00));
        vecs.push_back(mk("rsp_arb",   4'b1000, 1'b0, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("rsp_g",     4'b1000, 1'b0, 32'h00000001, 2'b01, 2'd1, 2'b10, 2'b01, 32'h00000001, 32'h0,        2'b01, 2'b00));
        vecs.push_back(mk("rw_arb",    4'b0011, 1'b0, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("rw_g",      4'b0011, 1'b0, 32'h0,        2'b00, 2'd2, 2'b11, 2'b10, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("w0_arb",    4'b0100, 1'b0, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("w0_g",      4'b0100, 1'b0, 32'h00000077, 2'b00, 2'd1, 2'b01, 2'b01, 32'h00000077, 32'h0,        2'b00, 2'b00));
        vecs.push_back(mk("end_idle",  4'b0000, 1'b0, 32'h0,        2'b00, 2'd0, 2'b00, 2'b11, 32'h0,        32'h0,        2'b00, 2'b00));

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset during an m1 stall: slave request drops without a clock edge, m0 wins afterwards.
        @(negedge clk);
        {m0_read, m0_write, m1_read, m1_write} = 4'b0010;
        s_waitrequest = 1'b1; s_readdata = '0; s_response = 2'b00;
        #1 check("rst_pre_arb", 141'({s_read, m1_waitrequest}), 141'(2'b01));
        @(negedge clk);
        #1 check("rst_m1_busy", 141'({s_read, s_addr}), 141'({1'b1, M1_ADDR}));
        #1 rst_n = 1'b0;
        #1 check("rst_async_drop", 141'({s_read, s_write, m0_waitrequest, m1_waitrequest}), 141'(4'b0011));
        @(negedge clk);
        rst_n = 1'b1;
        m0_read = 1'b1; m1_read = 1'b1;
        #1 check("rst_rel_idle", 141'({s_read, m0_waitrequest, m1_waitrequest}), 141'(3'b011));
        @(negedge clk);
        #1 check("rst_m0_first", 141'({s_read, s_addr, m1_waitrequest}), 141'({1'b1, M0_ADDR, 1'b1}));
        @(negedge clk);
        {m0_read, m0_write, m1_read, m1_write} = 4'b0000;
        s_waitrequest = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Slave that never releases waitrequest.
        {m0_read, m0_write, m1_read, m1_write} = 4'b1000;
        s_waitrequest = 1'b1; s_readdata = 32'hFFFF_FFFF; s_response = 2'b00;
        ok = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
        for (int k = 1; k < int'(TO); k++) begin
            @(negedge clk);
            #1 if (!(m0_waitrequest && !timeout_o && s_read)) ok = 1'b0;
        end
        check("tmo_stall", 141'(ok), 141'(1'b1));
        @(negedge clk);
        #1 check("tmo_fire", 141'({m0_waitrequest, m0_response, m0_readdata, s_read, timeout_o}),
                 141'({1'b0, 2'b11, 32'h0, 1'b0, 1'b1}));
        @(negedge clk);
        #1 check("tmo_after", 141'({timeout_o, s_read, m0_waitrequest}), 141'(3'b001));
`else
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            #1 if (!(m0_waitrequest && !timeout_o && s_read)) ok = 1'b0;
        end
        check("no_tmo_stall", 141'(ok), 141'(1'b1));
`endif
        @(negedge clk);
        {m0_read, m0_write, m1_read, m1_write} = 4'b0000;
        s_waitrequest = 1'b0;
        @(negedge clk);
        #1 check("final_idle", 141'({s_read, s_write, m0_waitrequest, m1_waitrequest, timeout_o}), 141'(5'b00110));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
